// File: rtl/dial_quad_frontend.sv
// dial_quad_frontend: x4 quadrature decoder, detent accumulator and modulo dial position.
// Define DIAL_GLITCH_CNT_EN to build the saturating illegal-transition counter.
module dial_quad_frontend #(
  parameter int DIAL_STEPS = 40,
  parameter int DETENT_DIV = 4,
  parameter int CODE0      = 12,
  parameter int CODE1      = 27,
  parameter int CODE2      = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       qa,
  input  logic       qb,
  input  logic       countEn,
  input  logic       clrCount,
  input  logic [1:0] sel,
  output logic       cnten,
  output logic       up,
  output logic       dirch,
  output logic       eq,
  output logic [5:0] pos,
  output logic [7:0] glitch_cnt
);
  localparam int AW = $clog2(DETENT_DIV + 1);
  logic [1:0] s1, s2, q_prev, d;
  logic primed, acc_dir, has_dir, step_v, step_dir, mv, mdir, done;
  logic [AW-1:0] acc, nacc;
  logic [5:0] code, pos_cw, pos_ccw;
  function automatic logic [1:0] g2i(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction
  // Gray codes mapped to a 2-bit ring index: +1 is clockwise, +3 counter-clockwise, +2 illegal
  assign d       = g2i(s2) - g2i(q_prev);
  assign mv      = primed && d[0];
  assign mdir    = d == 2'd1;
  assign nacc    = (mdir == acc_dir) ? acc + AW'(1) : AW'(1);
  assign done    = mv && nacc == AW'(DETENT_DIV);
  assign code    = sel == 2'd0 ? 6'(CODE0) : sel == 2'd1 ? 6'(CODE1) : 6'(CODE2);
  assign pos_cw  = pos == 6'(DIAL_STEPS - 1) ? '0 : pos + 6'd1;
  assign pos_ccw = pos == '0 ? 6'(DIAL_STEPS - 1) : pos - 6'd1;
  // A completed detent is staged in step_v and applied one cycle later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
      q_prev <= '0;
      primed <= 1'b0;
      acc <= '0;
      acc_dir <= 1'b1;
      step_v <= 1'b0;
      step_dir <= 1'b1;
      has_dir <= 1'b0;
      cnten <= 1'b0;
      up <= 1'b1;
      dirch <= 1'b0;
      eq <= 1'b0;
      pos <= '0;
    end else begin
      s1 <= {qa, qb};
      s2 <= s1;
      q_prev <= s2;
      primed <= 1'b1;
      eq <= pos == code;
      cnten <= 1'b0;
      dirch <= 1'b0;
      step_v <= 1'b0;
      if (clrCount) begin
        pos <= '0;
        acc <= '0;
        has_dir <= 1'b0;
      end else begin
        if (mv) begin
          acc <= done ? '0 : nacc;
          acc_dir <= mdir;
          step_v <= done;
          step_dir <= mdir;
        end
        if (step_v && countEn) begin
          cnten <= 1'b1;
          up <= step_dir;
          pos <= step_dir ? pos_cw : pos_ccw;
          dirch <= has_dir && step_dir != up;
          has_dir <= 1'b1;
        end
      end
    end
  end
`ifdef DIAL_GLITCH_CNT_EN
  logic ill;
  assign ill = primed && d == 2'd2;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) glitch_cnt <= '0;
    else if (ill && glitch_cnt != 8'hff) glitch_cnt <= glitch_cnt + 8'd1;
  end
`else
  assign glitch_cnt = '0;
`endif
endmodule

// File: tb/tb_dial_quad_frontend.sv
// tb_dial_quad_frontend: directed and random encoder walks checked against a detent-level model.
module tb_dial_quad_frontend;
  logic clk = 0, rst = 0, qa = 0, qb = 0, countEn = 1, clrCount = 0;
  logic [1:0] sel = 0;
  logic cnten, up, dirch, eq;
  logic [5:0] pos;
  logic [7:0] glitch_cnt;
  int vectors = 0, errs = 0;
  int n_cnten = 0, n_dirch = 0, exp_steps = 0, exp_dirch = 0;
  int gi = 0, m_acc = 0, m_pos = 0, p;
  bit m_dir = 1, m_up = 1, m_has = 0;
  logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  dial_quad_frontend dut (.clk(clk), .rst(rst), .qa(qa), .qb(qb), .countEn(countEn),
    .clrCount(clrCount), .sel(sel), .cnten(cnten), .up(up), .dirch(dirch), .eq(eq),
    .pos(pos), .glitch_cnt(glitch_cnt));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (cnten === 1'b1) n_cnten++;
    if (dirch === 1'b1) n_dirch++;
  end

  function automatic int code_of(input logic [1:0] s);
    return s == 0 ? 12 : s == 1 ? 27 : 5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One Gray transition on the pins; the model works in whole detents of four transitions
  task automatic move(input int dr, input int w, input bit drop);
    bit cw;
    @(negedge clk);
    gi = (gi + dr + 4) % 4;
    {qa, qb} = gray[gi];
    cw = dr > 0;
    m_acc = (cw == m_dir) ? m_acc + 1 : 1;
    m_dir = cw;
    if (m_acc == 4) begin
      m_acc = 0;
      if (!drop && countEn) begin
        if (m_has && m_up != cw) exp_dirch++;
        m_up = cw;
        m_has = 1;
        m_pos = (m_pos + (cw ? 1 : 39)) % 40;
        exp_steps++;
      end
    end
    repeat (w) @(posedge clk);
  endtask

  task automatic detent(input int dr, input int n);
    repeat (n) repeat (4) move(dr, 6, 0);
  endtask

  task automatic model_clr();
    m_pos = 0;
    m_acc = 0;
    m_has = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cnten", cnten, 0);
    chk("rst_up", up, 1);
    chk("rst_dirch", dirch, 0);
    chk("rst_eq", eq, 0);
    chk("rst_pos", pos, 0);
    chk("rst_glitch", glitch_cnt, 0);
    @(negedge clk) rst = 1;
    repeat (3) @(posedge clk);

    repeat (3) move(1, 6, 0);
    move(1, 0, 0);
    repeat (3) @(posedge clk);
    #1 chk("lat_n2_cnten", cnten, 0);
    chk("lat_n2_pos", pos, 0);
    @(posedge clk); #1;
    chk("lat_n3_cnten", cnten, 1);
    chk("lat_n3_pos", pos, 1);
    chk("lat_n3_up", up, 1);
    chk("lat_n3_dirch", dirch, 0);
    @(posedge clk); #1;
    chk("lat_n4_cnten", cnten, 0);

    detent(1, 38);
    chk("pos39", pos, m_pos);
    detent(1, 1);
    chk("wrap_cw", pos, 0);
    detent(-1, 1);
    chk("wrap_ccw", pos, 39);
    chk("ccw_up", up, 0);
    chk("dirch_pulses", n_dirch, exp_dirch);

    detent(1, 12);
    repeat (3) move(1, 6, 0);
    move(1, 0, 0);
    repeat (4) @(posedge clk);
    #1 chk("eq_pos12", pos, 12);
    chk("eq_lag", eq, 0);
    @(posedge clk); #1;
    chk("eq_hit", eq, 1);
    @(negedge clk) sel = 1;
    @(posedge clk); #1;
    chk("eq_sel1", eq, 0);

    @(negedge clk) countEn = 0;
    p = m_pos;
    detent(1, 3);
    chk("cnten_off_pos", pos, p);
    chk("cnten_off_pulses", n_cnten, exp_steps);
    @(negedge clk) countEn = 1;
    detent(1, 1);
    chk("cnten_on_pos", pos, (p + 1) % 40);

    p = m_pos;
    repeat (2) move(1, 6, 0);
    repeat (4) move(-1, 6, 0);
    chk("partial_pos", pos, (p + 39) % 40);
    chk("partial_pulses", n_cnten, exp_steps);

    repeat (3) move(1, 6, 0);
    move(1, 0, 1);
    repeat (3) @(posedge clk);
    @(negedge clk) clrCount = 1;
    model_clr();
    @(posedge clk); #1;
    chk("clr_pos", pos, 0);
    chk("clr_cnten", cnten, 0);
    @(negedge clk) clrCount = 0;
    repeat (4) @(posedge clk);
    chk("clr_pulses", n_cnten, exp_steps);

    for (int i = 0; i < 160; i++) begin
      countEn = ($urandom_range(0, 3) != 0);
      move(($urandom_range(0, 2) != 0) ? 1 : -1, 6, 0);
      if (i % 16 == 15) begin
        chk("rand_pos", pos, m_pos);
        @(negedge clk) sel = 2'($urandom_range(0, 3));
        repeat (2) @(posedge clk);
        #1 chk("rand_eq", eq, (m_pos == code_of(sel)) ? 1 : 0);
      end
    end
    countEn = 1;
    chk("rand_pulses", n_cnten, exp_steps);
    chk("rand_dirch", n_dirch, exp_dirch);
    chk("rand_up", up, m_up);

    p = m_pos;
`ifdef DIAL_GLITCH_CNT_EN
    repeat (150) begin
`else
    repeat (4) begin
`endif
      @(negedge clk) {qa, qb} = gray[(gi + 2) % 4];
      repeat (4) @(posedge clk);
      @(negedge clk) {qa, qb} = gray[gi];
      repeat (4) @(posedge clk);
    end
    repeat (3) @(posedge clk);
    #1 chk("glitch_pos", pos, p);
`ifdef DIAL_GLITCH_CNT_EN
    chk("glitch_sat", glitch_cnt, 255);
`else
    chk("glitch_off", glitch_cnt, 0);
`endif
    @(negedge clk) clrCount = 1;
    model_clr();
    @(negedge clk) clrCount = 0;
    #1 chk("clr_keeps_glitch", glitch_cnt, glitch_cnt == 8'hff ? 255 : 0);
    chk("clr2_pos", pos, 0);

    detent(1, 2);
    repeat (2) move(1, 6, 0);
    @(negedge clk);
    rst = 0;
    {qa, qb} = 2'b00;
    gi = 0;
    #1 chk("arst_pos", pos, 0);
    chk("arst_up", up, 1);
    m_acc = 0; m_pos = 0; m_dir = 1; m_up = 1; m_has = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1;
    repeat (3) @(posedge clk);
    detent(1, 1);
    chk("rearm_pos", pos, 1);
    chk("rearm_pulses", n_cnten, exp_steps);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
